// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by an internal write FIFO.
// Frame: start, N_BIT data bits LSB first, optional parity, N_STOP stop bits.
module uart_tx_fifo #(
    parameter int N_BIT   = 8,
    parameter int N_TICK  = 16,
    parameter int PARITY  = 0,
    parameter int N_STOP  = 1,
    parameter int FIFO_AW = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             TICK,
    input  logic             WR_EN,
    input  logic [N_BIT-1:0] DIN,
    output logic             FULL,
    output logic             EMPTY,
    output logic             TX,
    output logic             TX_DONE,
    output logic             BUSY,
    output logic [2:0]       STATE
);

    localparam int DEPTH = 2**FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam int TW    = $clog2(N_TICK);
    localparam int BW    = $clog2(N_BIT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    logic [N_BIT-1:0]   mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               push, pop;
    logic [N_BIT-1:0]   head;

    state_t             state_q, state_d;
    logic [TW-1:0]      tick_q, tick_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic               stop_q, stop_d;
    logic [N_BIT-1:0]   shift_q, shift_d;
    logic               par_q, par_d;
    logic               tx_q, tx_d;
    logic               done_q, done_d;
    logic               bit_end;

    assign head = mem_q[rd_ptr_q];

    // A write while full is dropped even if the transmitter pops in the same cycle.
    always_comb begin
        push     = WR_EN && !full_q;
        pop      = (state_q == S_IDLE) && !empty_q;
        wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= DIN;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = 1'b1;
        done_d  = 1'b0;
        bit_end = TICK && (tick_q == TW'(N_TICK - 1));

        if (state_q != S_IDLE && TICK) begin
            tick_d = bit_end ? '0 : tick_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!empty_q) begin
                    shift_d = head;
                    par_d   = (PARITY == 2) ? ~(^head) : ^head;
                    tick_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BW'(N_BIT - 1)) begin
                        stop_d  = 1'b0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            S_PAR: begin
                tx_d = par_q;
                if (bit_end) begin
                    stop_d  = 1'b0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (stop_q == 1'(N_STOP - 1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign FULL    = full_q;
    assign EMPTY   = empty_q;
    assign TX      = tx_q;
    assign TX_DONE = done_q;
    assign BUSY    = (state_q != S_IDLE);
    assign STATE   = state_q;

endmodule
